// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types, word geometry and packing helper for the code lock
//
// Purpose: FSM state encoding, default symbol width / word length, and the
//          helper that maps a symbol position to its bit offset in a word.
// Ports:   none (package).
package lock_pkg;

  localparam int SYM_W  = 2;
  localparam int DIGITS = 4;

  typedef enum logic [2:0] {
    ENTER     = 3'd0,
    COMPARE   = 3'd1,
    UNLOCKED  = 3'd2,
    PROGRAM   = 3'd3,
    PROG_DONE = 3'd4,
    LOCKOUT   = 3'd5
  } state_t;

  // Bit offset of symbol slot 'pos' inside a packed word; slot 0 is the LSBs.
  function automatic int unsigned sym_lsb(input int unsigned pos, input int unsigned sym_w);
    return pos * sym_w;
  endfunction

endpackage

// File: rtl/keypad_edge.sv
// rtl/keypad_edge.sv - button release tracking and one-hot to symbol encoding
//
// Purpose: qualifies a button press as a symbol only when exactly one button
//          is high and all buttons were low on the previous cycle.
// Ports:   clk, reset (async active-low), btn (one bit per symbol),
//          sym_valid (press accepted this cycle), sym (encoded symbol).
module keypad_edge import lock_pkg::*; #(
  parameter int SYM_W = lock_pkg::SYM_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [(1<<SYM_W)-1:0]   btn,
  output logic                    sym_valid,
  output logic [SYM_W-1:0]        sym
);

  localparam int NBTN = 1 << SYM_W;

  logic released_q;
  logic one_hot;

  // Remembers whether the previous cycle had every button up; a held or
  // chorded press keeps this low so nothing further is accepted until release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      released_q <= 1'b1;
    end else begin
      released_q <= (btn == '0);
    end
  end

  always_comb begin
    one_hot = (btn != '0) && ((btn & (btn - NBTN'(1))) == '0);
    sym     = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (btn[i]) sym = SYM_W'(i);
    end
    sym_valid = one_hot && released_q;
  end

endmodule

// File: rtl/lock_seq_ctrl.sv
// rtl/lock_seq_ctrl.sv - code-lock sequencing FSM: entry, compare, lockout, reprogramming
//
// Purpose: assembles accepted symbols into guess/key words, compares guesses
//          against the stored key, counts failed attempts, enforces a timed
//          lockout and gates key reprogramming behind a successful unlock.
// Ports:   clk, reset (async active-low), btn, edit (program switch),
//          clr (clear/relock, edge-detected); outputs key, guess, digit_cnt,
//          hits, attempts_left, result_valid, unlocked, alarm, prog_done,
//          state. All outputs are registered.
module lock_seq_ctrl import lock_pkg::*; #(
  parameter int DIGITS         = lock_pkg::DIGITS,
  parameter int SYM_W          = lock_pkg::SYM_W,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [(1<<SYM_W)-1:0]              btn,
  input  logic                               edit,
  input  logic                               clr,
  output logic [DIGITS*SYM_W-1:0]            key,
  output logic [DIGITS*SYM_W-1:0]            guess,
  output logic [$clog2(DIGITS+1)-1:0]        digit_cnt,
  output logic [$clog2(DIGITS+1)-1:0]        hits,
  output logic [$clog2(MAX_TRIES+1)-1:0]     attempts_left,
  output logic                               result_valid,
  output logic                               unlocked,
  output logic                               alarm,
  output logic                               prog_done,
  output logic [2:0]                         state
);

  localparam int WW = DIGITS * SYM_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int AW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  state_t          st;
  logic [WW-1:0]   shadow;
  logic [LW-1:0]   lock_cnt;
  logic            clr_q;
  logic            clr_rise;

  logic            sym_valid;
  logic [SYM_W-1:0] sym;

  logic [CW-1:0]   hit_cnt;
  logic [WW-1:0]   guess_ins;
  logic [WW-1:0]   shadow_ins;
  logic            last_sym;
  int unsigned     lsb;

  keypad_edge #(.SYM_W(SYM_W)) u_keypad (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .sym_valid (sym_valid),
    .sym       (sym)
  );

  assign clr_rise = clr && !clr_q;
  assign state    = st;

  // Next-word values with the incoming symbol dropped into slot digit_cnt,
  // plus the positional match count used in COMPARE.
  always_comb begin
    lsb        = sym_lsb(32'(digit_cnt), SYM_W);
    guess_ins  = guess;
    shadow_ins = shadow;
    if (digit_cnt < CW'(DIGITS)) begin
      guess_ins[lsb +: SYM_W]  = sym;
      shadow_ins[lsb +: SYM_W] = sym;
    end
    last_sym = (digit_cnt == CW'(DIGITS - 1));
    hit_cnt  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (guess[i*SYM_W +: SYM_W] == key[i*SYM_W +: SYM_W]) hit_cnt = hit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= ENTER;
      key           <= '0;
      guess         <= '0;
      shadow        <= '0;
      digit_cnt     <= '0;
      hits          <= '0;
      attempts_left <= AW'(MAX_TRIES);
      result_valid  <= 1'b0;
      unlocked      <= 1'b0;
      alarm         <= 1'b0;
      prog_done     <= 1'b0;
      lock_cnt      <= '0;
      clr_q         <= 1'b0;
    end else begin
      clr_q        <= clr;
      result_valid <= 1'b0;
      prog_done    <= 1'b0;

      case (st)
        ENTER: begin
          // clr wins over a symbol landing on the same edge.
          if (clr_rise) begin
            guess     <= '0;
            digit_cnt <= '0;
          end else if (sym_valid) begin
            guess     <= guess_ins;
            digit_cnt <= digit_cnt + CW'(1);
            if (last_sym) st <= COMPARE;
          end
        end

        COMPARE: begin
          hits         <= hit_cnt;
          result_valid <= 1'b1;
          if (hit_cnt == CW'(DIGITS)) begin
            st            <= UNLOCKED;
            unlocked      <= 1'b1;
            attempts_left <= AW'(MAX_TRIES);
          end else begin
            attempts_left <= attempts_left - AW'(1);
            digit_cnt     <= '0;
            if (attempts_left == AW'(1)) begin
              st       <= LOCKOUT;
              alarm    <= 1'b1;
              lock_cnt <= '0;
            end else begin
              st <= ENTER;
            end
          end
        end

        UNLOCKED: begin
          if (edit) begin
            st        <= PROGRAM;
            unlocked  <= 1'b0;
            shadow    <= '0;
            digit_cnt <= '0;
          end else if (clr_rise) begin
            st        <= ENTER;
            unlocked  <= 1'b0;
            guess     <= '0;
            digit_cnt <= '0;
          end
        end

        PROGRAM: begin
          // Leaving edit early throws away the partial key.
          if (!edit) begin
            st        <= UNLOCKED;
            unlocked  <= 1'b1;
            shadow    <= '0;
            digit_cnt <= '0;
          end else if (sym_valid) begin
            shadow    <= shadow_ins;
            digit_cnt <= digit_cnt + CW'(1);
            if (last_sym) begin
              key       <= shadow_ins;
              prog_done <= 1'b1;
              st        <= PROG_DONE;
            end
          end
        end

        PROG_DONE: begin
          if (!edit) begin
            st        <= ENTER;
            guess     <= '0;
            digit_cnt <= '0;
          end
        end

        LOCKOUT: begin
          if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) begin
            st            <= ENTER;
            alarm         <= 1'b0;
            attempts_left <= AW'(MAX_TRIES);
            digit_cnt     <= '0;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end

        default: st <= ENTER;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb/tb_lock_seq_ctrl.sv - self-checking bench for lock_seq_ctrl
module tb_lock_seq_ctrl;
  import lock_pkg::*;

  localparam int LOCK_N = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       edit;
  logic       clr;
  logic [7:0] key;
  logic [7:0] guess;
  logic [2:0] digit_cnt;
  logic [2:0] hits;
  logic [1:0] attempts_left;
  logic       result_valid;
  logic       unlocked;
  logic       alarm;
  logic       prog_done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  lock_seq_ctrl #(
    .DIGITS(4), .SYM_W(2), .MAX_TRIES(3), .LOCKOUT_CYCLES(LOCK_N)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .edit(edit), .clr(clr),
    .key(key), .guess(guess), .digit_cnt(digit_cnt), .hits(hits),
    .attempts_left(attempts_left), .result_valid(result_valid),
    .unlocked(unlocked), .alarm(alarm), .prog_done(prog_done), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int s);
    btn = 4'(1 << s);
    tick();
    btn = 4'd0;
    tick();
  endtask

  // Positional symbol matches between two codes, symbol by symbol.
  function automatic int hits_of(input logic [7:0] g, input logic [7:0] k);
    int n = 0;
    for (int i = 0; i < 4; i++)
      if (((g >> (2*i)) & 8'd3) == ((k >> (2*i)) & 8'd3)) n++;
    return n;
  endfunction

  // Enters four symbols, checking the COMPARE cycle; returns after E+1.
  task automatic enter_code(input logic [7:0] code);
    for (int i = 0; i < 3; i++) press(int'((code >> (2*i)) & 8'd3));
    btn = 4'(1 << int'((code >> 6) & 8'd3));
    tick();
    check("cmp_state", 32'(state), 32'(COMPARE));
    check("cmp_cnt", 32'(digit_cnt), 32'd4);
    btn = 4'd0;
    tick();
    check("res_valid", 32'(result_valid), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_key"}, 32'(key), 32'd0);
    check({tag, "_guess"}, 32'(guess), 32'd0);
    check({tag, "_cnt"}, 32'(digit_cnt), 32'd0);
    check({tag, "_hits"}, 32'(hits), 32'd0);
    check({tag, "_att"}, 32'(attempts_left), 32'd3);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_unl"}, 32'(unlocked), 32'd0);
    check({tag, "_alarm"}, 32'(alarm), 32'd0);
    check({tag, "_pd"}, 32'(prog_done), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(ENTER));
  endtask

  logic [7:0] model_key;
  int         model_att;
  int         n;
  logic [7:0] g;
  int         h;

  initial begin
    reset = 1'b0; btn = 4'd0; edit = 1'b0; clr = 1'b0;
    tick(); tick();
    check_reset_vals("rst");
    reset = 1'b1;
    tick();
    check("rst_rel_state", 32'(state), 32'(ENTER));

    // Default all-zero code unlocks.
    model_key = 8'h00;
    enter_code(8'h00);
    check("u0_hits", 32'(hits), 32'(hits_of(8'h00, model_key)));
    check("u0_unl", 32'(unlocked), 32'd1);
    check("u0_att", 32'(attempts_left), 32'd3);
    check("u0_state", 32'(state), 32'(UNLOCKED));
    tick();
    check("u0_rv_pulse", 32'(result_valid), 32'd0);

    // Program key 3,2,1,0.
    edit = 1'b1;
    tick();
    check("prog_state", 32'(state), 32'(PROGRAM));
    press(3); press(2); press(1);
    btn = 4'b0001;
    tick();
    check("pd_high", 32'(prog_done), 32'd1);
    check("pd_key", 32'(key), 32'h1B);
    check("pd_state", 32'(state), 32'(PROG_DONE));
    btn = 4'd0;
    tick();
    check("pd_low", 32'(prog_done), 32'd0);
    model_key = 8'h1B;
    edit = 1'b0;
    tick();
    check("pd_exit_state", 32'(state), 32'(ENTER));
    check("pd_exit_guess", 32'(guess), 32'd0);
    check("pd_exit_cnt", 32'(digit_cnt), 32'd0);

    // Three wrong guesses then timed lockout.
    for (int t = 0; t < 3; t++) begin
      enter_code(8'h00);
      check("wr_hits", 32'(hits), 32'(hits_of(8'h00, model_key)));
      check("wr_att", 32'(attempts_left), 32'(2 - t));
      check("wr_state", 32'(state), (t == 2) ? 32'(LOCKOUT) : 32'(ENTER));
    end
    check("lk_alarm0", 32'(alarm), 32'd1);
    for (int k = 1; k < LOCK_N; k++) begin
      btn = ((k % 2) == 1 && k < 13) ? 4'b0001 : 4'd0;
      clr = (k == 4);
      tick();
      check("lk_alarm", 32'(alarm), 32'd1);
      check("lk_cnt", 32'(digit_cnt), 32'd0);
    end
    btn = 4'd0; clr = 1'b0;
    tick();
    check("lk_end_alarm", 32'(alarm), 32'd0);
    check("lk_end_state", 32'(state), 32'(ENTER));
    check("lk_end_att", 32'(attempts_left), 32'd3);

    // Held button, chord, no-release.
    btn = 4'b0100;
    for (int k = 0; k < 10; k++) tick();
    check("hold_cnt", 32'(digit_cnt), 32'd1);
    check("hold_guess", 32'(guess[1:0]), 32'd2);
    btn = 4'd0; tick();
    btn = 4'b0110; tick(); btn = 4'd0; tick();
    check("chord_cnt", 32'(digit_cnt), 32'd1);
    btn = 4'b0100; tick();
    check("second_cnt", 32'(digit_cnt), 32'd2);
    btn = 4'b0010; tick();
    check("norel_cnt", 32'(digit_cnt), 32'd2);
    btn = 4'd0; tick();

    // clr clears partial entry, keeps attempts; clr beats a same-cycle symbol.
    clr = 1'b1; tick();
    check("clr_cnt", 32'(digit_cnt), 32'd0);
    check("clr_guess", 32'(guess), 32'd0);
    check("clr_att", 32'(attempts_left), 32'd3);
    clr = 1'b0; tick();
    press(1);
    check("pre_prio_cnt", 32'(digit_cnt), 32'd1);
    btn = 4'b1000; clr = 1'b1; tick();
    check("prio_cnt", 32'(digit_cnt), 32'd0);
    check("prio_guess", 32'(guess), 32'd0);
    btn = 4'd0; clr = 1'b0; tick();

    // Abort programming: key must survive.
    enter_code(model_key);
    check("u1_state", 32'(state), 32'(UNLOCKED));
    edit = 1'b1; tick();
    press(1); press(1);
    edit = 1'b0; tick();
    check("abort_state", 32'(state), 32'(UNLOCKED));
    check("abort_key", 32'(key), 32'(model_key));
    check("abort_unl", 32'(unlocked), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("relock_state", 32'(state), 32'(ENTER));
    check("relock_unl", 32'(unlocked), 32'd0);

    // Randomized guesses against the reference rules.
    model_att = 3;
    for (int t = 0; t < 24; t++) begin
      g = 8'($urandom);
      if ($urandom_range(0, 3) == 0) g = model_key;
      enter_code(g);
      h = hits_of(g, model_key);
      check("rnd_hits", 32'(hits), 32'(h));
      if (h == 4) begin
        model_att = 3;
        check("rnd_unl_state", 32'(state), 32'(UNLOCKED));
        check("rnd_unl_att", 32'(attempts_left), 32'(model_att));
        clr = 1'b1; tick(); clr = 1'b0;
        check("rnd_relock", 32'(state), 32'(ENTER));
      end else begin
        model_att--;
        check("rnd_att", 32'(attempts_left), 32'(model_att));
        if (model_att == 0) begin
          check("rnd_lk_state", 32'(state), 32'(LOCKOUT));
          n = 0;
          while (alarm && n < 4 * LOCK_N) begin
            tick();
            n++;
          end
          check("rnd_lk_len", 32'(n), 32'(LOCK_N));
          check("rnd_lk_exit", 32'(state), 32'(ENTER));
          check("rnd_lk_att", 32'(attempts_left), 32'd3);
          model_att = 3;
        end else begin
          check("rnd_state", 32'(state), 32'(ENTER));
        end
      end
    end

    // Reset asserted while in COMPARE.
    press(0); press(1); press(2);
    btn = 4'b1000; tick();
    check("rc_state", 32'(state), 32'(COMPARE));
    reset = 1'b0;
    #1;
    check_reset_vals("rc");
    btn = 4'd0;
    tick();
    check("rc_rv", 32'(result_valid), 32'd0);
    check("rc_key", 32'(key), 32'd0);
    reset = 1'b1;
    tick();
    check("rc_after_state", 32'(state), 32'(ENTER));
    check("rc_after_rv", 32'(result_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_seq_ctrl.md
# lock_seq_ctrl

Sequencing controller for the four-button code-lock datapath. It turns raw button presses into 2-bit symbols, assembles them into 4-symbol guess and key words, and compares each completed guess against the stored key. It also counts failed attempts, enforces a timed lockout, and gates key reprogramming behind a successful unlock. It sits between the board buttons/switches and the display/LED logic and replaces ad-hoc per-button sequencing with one explicit FSM.

## Interface
- DIGITS, 4, symbols per code word
- SYM_W, 2, bits per symbol
- MAX_TRIES, 3, failed guesses allowed before lockout
- LOCKOUT_CYCLES, 1000, clk cycles spent in LOCKOUT
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- btn  in  4  buttons, synchronized upstream; btn[n] encodes symbol n
- edit  in  1  program-mode switch (level)
- clr  in  1  clear partial entry / relock (level, edge-detected)
- key  out  DIGITS*SYM_W  stored key
- guess  out  DIGITS*SYM_W  guess being or last entered
- digit_cnt  out  $clog2(DIGITS+1)  symbols entered in current word
- hits  out  $clog2(DIGITS+1)  symbols matching key in position, last compare
- attempts_left  out  $clog2(MAX_TRIES+1)  remaining tries
- result_valid  out  1  one-cycle pulse when hits/unlocked update
- unlocked  out  1  high in UNLOCKED
- alarm  out  1  high in LOCKOUT
- prog_done  out  1  one-cycle pulse when new key committed
- state  out  3  FSM state for debug/display

## Operation
- Reset values: key=0, guess=0, digit_cnt=0, hits=0, attempts_left=MAX_TRIES, all flags 0, state=ENTER. The default code is therefore all-zero.
- Press acceptance:
  - A symbol is accepted on the cycle in which exactly one btn bit is high and all btn bits were low on the previous cycle.
  - Multi-button combinations are ignored. A held button yields one symbol.
  - A new symbol requires a full release (all btn low) first.
- Packing: symbol k (k = digit_cnt at acceptance) is written to word bits [k*SYM_W +: SYM_W]. The first symbol goes to bits [1:0].
- States and transitions:
  - ENTER: accepted symbols go to guess. On the DIGITS-th symbol, go to COMPARE. A clr rising edge zeroes guess and digit_cnt; attempts are unchanged. edit is ignored.
  - COMPARE: a single cycle. hits = count of positions with equal symbols; result_valid pulses.
    - On full match: go to UNLOCKED and restore attempts_left=MAX_TRIES.
    - Otherwise decrement attempts_left. If it reaches 0, go to LOCKOUT; else go to ENTER.
    - In both non-match cases digit_cnt=0.
  - UNLOCKED: unlocked=1. edit=1 goes to PROGRAM. A clr rising edge goes to ENTER (relock).
  - PROGRAM: accepted symbols go to an internal shadow word. On the DIGITS-th symbol, commit key<=shadow, pulse prog_done, go to PROG_DONE. If edit falls before completion, discard the shadow, leave key unchanged, and go to UNLOCKED.
  - PROG_DONE: wait for edit=0, then go to ENTER with guess=0 and digit_cnt=0.
  - LOCKOUT: alarm=1. Buttons and clr are ignored; the cycle counter runs to LOCKOUT_CYCLES-1. Then go to ENTER with attempts_left=MAX_TRIES.
- Simultaneous events in ENTER: clr takes priority over a symbol accepted in the same cycle.
- Reset asserted mid-operation returns every output to its reset value, including key.

## Timing
- Final symbol sampled at edge E.
  - E: state=COMPARE, digit_cnt=DIGITS.
  - E+1: hits, unlocked/attempts_left, and state updated; result_valid is high for the cycle after E+1.
- prog_done is high for the one cycle after the committing edge. key changes on that same edge.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package lock_pkg holds:
  - state enum (ENTER, COMPARE, UNLOCKED, PROGRAM, PROG_DONE, LOCKOUT)
  - SYM_W, DIGITS
  - a symbol-to-position helper function
- Sub-module keypad_edge handles release tracking, single-button qualification, and one-hot-to-symbol encoding. It outputs sym_valid and sym[SYM_W-1:0].
- Top level contains the FSM, guess/shadow/key registers, hit counter, attempt counter and lockout counter.

## Test plan
- Reset, then press btn[0] four times → after E+1: unlocked=1, hits=4, attempts_left=3, state=UNLOCKED.
- From UNLOCKED with edit=1, press btn[3],btn[2],btn[1],btn[0] → key=8'h1B, prog_done pulses once. Drop edit → state=ENTER, guess=0.
- With key=8'h1B (bench sets LOCKOUT_CYCLES=16), enter 0,0,0,0 three times:
  - each compare gives hits=1; attempts_left goes 2, 1, 0;
  - then alarm=1 for exactly 16 cycles with presses ignored;
  - then state=ENTER, attempts_left=3.
- Hold btn[2] for 10 cycles → one symbol accepted. Press btn[1]|btn[2] together → no symbol. Press btn[1] without releasing after a prior symbol → no symbol.
- In ENTER after 2 symbols, raise clr → digit_cnt=0, guess=0, attempts unchanged. In PROGRAM after 2 symbols, drop edit → key unchanged, state=UNLOCKED.
- Assert reset during COMPARE → all outputs at reset values next cycle, key=0, no result_valid pulse.
